// File: rtl/nem_ohmux_pkg.sv
// Shared types and helpers for the nem_ohmux select controller: FSM states,
// default relay timing, and the encoded-to-one-hot select decoder.
package nem_ohmux_pkg;

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    BREAK  = 2'd1,
    MAKE   = 2'd2,
    CLOSED = 2'd3
  } sel_state_e;

  localparam int unsigned DEF_N_IN    = 2;
  localparam int unsigned DEF_T_OPEN  = 2;
  localparam int unsigned DEF_T_CLOSE = 3;

  // Decoder works at a fixed maximum width; callers cast the result down to N_IN.
  localparam int unsigned OH_SELW = 8;
  localparam int unsigned OH_MAXW = 1 << OH_SELW;

  function automatic logic [OH_MAXW-1:0] onehot(input logic [OH_SELW-1:0] sel);
    logic [OH_MAXW-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/nem_ohmux_dly_cnt.sv
// Loadable down-counter for relay release/actuation delays; saturates at zero
// and flags done while it sits there.
module nem_ohmux_dly_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select driver for nem_ohmux relay mux banks.
// Define NEM_OHMUX_SEL_CHK_EN to build the sticky ERR checker; otherwise ERR is 0.
module nem_ohmux_sel_ctrl
  import nem_ohmux_pkg::*;
#(
  parameter int unsigned N_IN    = DEF_N_IN,
  parameter int unsigned T_OPEN  = DEF_T_OPEN,
  parameter int unsigned T_CLOSE = DEF_T_CLOSE,
  parameter int unsigned SELW    = $clog2(N_IN)
) (
  input  logic            CP,
  input  logic            CD,
  input  logic            REQ_VALID,
  input  logic            REQ_OPEN,
  input  logic [SELW-1:0] REQ_SEL,
  output logic            REQ_READY,
  output logic [N_IN-1:0] S,
  output logic            SEL_VALID,
  output logic [SELW-1:0] CUR_SEL,
  output logic            ERR
);

  localparam int unsigned T_MAX = (T_OPEN > T_CLOSE) ? T_OPEN : T_CLOSE;
  localparam int unsigned CW    = $clog2(T_MAX + 1);
  localparam logic [CW-1:0] T_OPEN_M1  = CW'(T_OPEN - 1);
  localparam logic [CW-1:0] T_CLOSE_M1 = CW'(T_CLOSE - 1);

  sel_state_e      state;
  logic [N_IN-1:0] s_q;
  logic            sel_valid_q;
  logic [SELW-1:0] cur_sel_q;
  logic            pend_q;
  logic            ready_q;

  logic            accept;
  logic            sel_oor;
  logic            open_req;
  logic            changes;
  logic [N_IN-1:0] oh_req;
  logic [N_IN-1:0] oh_cur;
  logic            cnt_load;
  logic [CW-1:0]   cnt_val;
  logic            cnt_done;

  assign accept   = REQ_VALID && ready_q;
  assign sel_oor  = (32'(REQ_SEL) >= N_IN);
  assign open_req = REQ_OPEN || sel_oor;
  assign changes  = open_req || (REQ_SEL != cur_sel_q);
  assign oh_req   = N_IN'(onehot(OH_SELW'(REQ_SEL)));
  assign oh_cur   = N_IN'(onehot(OH_SELW'(cur_sel_q)));

  // Counter is loaded on entry to each timed state so its expiry lines up with the FSM exit edge.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      OPEN: begin
        if (accept && !open_req) begin
          cnt_load = 1'b1;
          cnt_val  = T_CLOSE_M1;
        end
      end
      CLOSED: begin
        if (accept && changes) begin
          cnt_load = 1'b1;
          cnt_val  = T_OPEN_M1;
        end
      end
      BREAK: begin
        if (cnt_done && pend_q) begin
          cnt_load = 1'b1;
          cnt_val  = T_CLOSE_M1;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  nem_ohmux_dly_cnt #(
    .W (CW)
  ) u_dly_cnt (
    .clk      (CP),
    .rst      (CD),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state       <= OPEN;
      s_q         <= '0;
      sel_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state)
        OPEN: begin
          if (accept && !open_req) begin
            state     <= MAKE;
            s_q       <= oh_req;
            cur_sel_q <= REQ_SEL;
            ready_q   <= 1'b0;
          end
        end
        CLOSED: begin
          // Same-target requests fall through untouched so S never glitches.
          if (accept && changes) begin
            state       <= BREAK;
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            pend_q      <= !open_req;
            if (!open_req) begin
              cur_sel_q <= REQ_SEL;
            end
          end
        end
        BREAK: begin
          if (cnt_done) begin
            if (pend_q) begin
              state <= MAKE;
              s_q   <= oh_cur;
            end else begin
              state   <= OPEN;
              ready_q <= 1'b1;
            end
            pend_q <= 1'b0;
          end
        end
        MAKE: begin
          if (cnt_done) begin
            state       <= CLOSED;
            sel_valid_q <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state <= OPEN;
          s_q   <= '0;
        end
      endcase
    end
  end

  assign S         = s_q;
  assign SEL_VALID = sel_valid_q;
  assign CUR_SEL   = cur_sel_q;
  assign REQ_READY = ready_q;

`ifdef NEM_OHMUX_SEL_CHK_EN
  logic err_q;

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      err_q <= 1'b0;
    end else if (($countones(s_q) > 1) || (accept && !REQ_OPEN && sel_oor)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
